streaming_argmax: RTL and testbench

Streaming argmax over fixed-length vectors of classifier scores, with valid/ready flow control on both sides. It replaces the index-driven argmax cell. The element index is generated internally, signed and unsigned scores are both supported, the tie rule is selectable, and the winning score is reported alongside its index. It sits after the final dense layer and feeds the result/readback path.

---
 rtl/argmax_pkg.sv | 31 +++
 rtl/argmax_compare.sv | 36 +++
 rtl/streaming_argmax.sv | 119 +++++++++++
 tb/tb_streaming_argmax.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// Shared types and helpers for the streaming argmax block: FSM states,
// index sizing and the score comparison rule.
package argmax_pkg;

    // Scores are extended to this width before comparing; DATA_WIDTH must not exceed it.
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    function automatic int unsigned index_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // True when candidate a should replace the current best b.
    function automatic logic greater(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input logic                 signed_mode,
        input logic                 tie_last
    );
        logic gt;
        gt = signed_mode ? ($signed(a) > $signed(b)) : (a > b);
        return gt || (tie_last && (a == b));
    endfunction

endpackage

// File: rtl/argmax_compare.sv
// Combinational winner select between the running best and a candidate score.
module argmax_compare
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter bit SIGNED_DATA = 1'b0,
    parameter bit TIE_LAST    = 1'b1
) (
    input  logic [DATA_WIDTH-1:0]  best_value,
    input  logic [INDEX_WIDTH-1:0] best_index,
    input  logic [DATA_WIDTH-1:0]  cand_value,
    input  logic [INDEX_WIDTH-1:0] cand_index,
    output logic [DATA_WIDTH-1:0]  win_value,
    output logic [INDEX_WIDTH-1:0] win_index
);

    logic [MAX_WIDTH-1:0] best_ext;
    logic [MAX_WIDTH-1:0] cand_ext;
    logic                 cand_wins;

    generate
        if (SIGNED_DATA) begin : g_sext
            assign best_ext = MAX_WIDTH'($signed(best_value));
            assign cand_ext = MAX_WIDTH'($signed(cand_value));
        end else begin : g_zext
            assign best_ext = MAX_WIDTH'(best_value);
            assign cand_ext = MAX_WIDTH'(cand_value);
        end
    endgenerate

    assign cand_wins = greater(cand_ext, best_ext, SIGNED_DATA, TIE_LAST);
    assign win_value = cand_wins ? cand_value : best_value;
    assign win_index = cand_wins ? cand_index : best_index;

endmodule

// File: rtl/streaming_argmax.sv
// Streaming argmax over fixed-length score vectors with valid/ready on both
// sides and a single-entry result register.
module streaming_argmax
    import argmax_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int VECTOR_LENGTH = 10,
    parameter int INDEX_WIDTH   = index_width(VECTOR_LENGTH),
    parameter bit SIGNED_DATA   = 1'b0,
    parameter bit TIE_LAST      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_value,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic [DATA_WIDTH-1:0]  out_value,
    output logic                   out_error
);

    localparam logic [INDEX_WIDTH-1:0] LAST_SLOT = INDEX_WIDTH'(VECTOR_LENGTH - 1);

    state_t                 state;
    state_t                 next_state;
    logic [INDEX_WIDTH-1:0] count;
    logic [INDEX_WIDTH-1:0] best_index;
    logic [DATA_WIDTH-1:0]  best_value;
    logic [INDEX_WIDTH-1:0] win_index;
    logic [DATA_WIDTH-1:0]  win_value;
    logic [INDEX_WIDTH-1:0] next_index;
    logic [DATA_WIDTH-1:0]  next_value;
    logic                   accept;
    logic                   at_last_slot;
    logic                   vector_end;
    logic                   first_elem;

    assign in_ready     = !out_valid || out_ready;
    assign accept       = in_valid && in_ready;
    assign at_last_slot = (count == LAST_SLOT);
    assign vector_end   = accept && (at_last_slot || in_last);

    argmax_compare #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .SIGNED_DATA (SIGNED_DATA),
        .TIE_LAST    (TIE_LAST)
    ) u_compare (
        .best_value (best_value),
        .best_index (best_index),
        .cand_value (in_value),
        .cand_index (count),
        .win_value  (win_value),
        .win_index  (win_index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && !vector_end) next_state = ACCUM;
            ACCUM:   if (vector_end)            next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        first_elem = 1'b0;
        case (state)
            IDLE:    first_elem = 1'b1;
            default: first_elem = 1'b0;
        endcase
    end

    // The first element bypasses the compare: it seeds best or, alone, is the result.
    assign next_value = first_elem ? in_value : win_value;
    assign next_index = first_elem ? '0 : win_index;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            best_value <= '0;
            best_index <= '0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_value  <= '0;
            out_error  <= 1'b0;
        end else begin
            if (accept) begin
                if (vector_end) begin
                    count     <= '0;
                    out_index <= next_index;
                    out_value <= next_value;
                    out_error <= (in_last != at_last_slot);
                end else begin
                    count      <= count + INDEX_WIDTH'(1);
                    best_value <= next_value;
                    best_index <= next_index;
                end
            end
            if (vector_end) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_streaming_argmax.sv
// Directed bench for streaming_argmax: default, keep-earliest and signed instances share one input stream.
module tb_streaming_argmax;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_value;
    logic        in_last;
    logic        out_ready;

    logic        rdy_u, rdy_f, rdy_s;
    logic        ov_u, ov_f, ov_s;
    logic [3:0]  oi_u, oi_f, oi_s;
    logic [31:0] ovl_u, ovl_f, ovl_s;
    logic        oe_u, oe_f, oe_s;

    int unsigned n_cmp;
    int unsigned n_bad;
    int unsigned stalls;

    typedef struct {
        logic [31:0] vals [10];
        int unsigned n;
        logic        last;
        logic [3:0]  idx_tl;
        logic [3:0]  idx_tf;
        logic [31:0] value;
        logic        err;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] sneg [10];
    logic [31:0] clean [10];
    logic [31:0] stall_vec [10];

    streaming_argmax dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .in_value(in_value), .in_last(in_last), .out_valid(ov_u), .out_ready(out_ready),
        .out_index(oi_u), .out_value(ovl_u), .out_error(oe_u)
    );

    streaming_argmax #(.TIE_LAST(1'b0)) dut_f (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
        .in_value(in_value), .in_last(in_last), .out_valid(ov_f), .out_ready(out_ready),
        .out_index(oi_f), .out_value(ovl_f), .out_error(oe_f)
    );

    streaming_argmax #(.SIGNED_DATA(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .in_value(in_value), .in_last(in_last), .out_valid(ov_s), .out_ready(out_ready),
        .out_index(oi_s), .out_value(ovl_s), .out_error(oe_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Present one element and return #1 after the edge that accepts it.
    task automatic push(input logic [31:0] v, input logic l);
        int unsigned waited;
        waited   = 0;
        in_valid = 1'b1;
        in_value = v;
        in_last  = l;
        @(negedge clk);
        while (!rdy_u && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        stalls += waited;
        if (!rdy_u) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_timeout: in_ready got 0, expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; stalls = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_last = 1'b0; out_ready = 1'b1;

        tbl[0] = '{vals: '{32'd3, 32'd7, 32'd1, 32'd9, 32'd9, 32'd2, 32'd0, 32'd4, 32'd8, 32'd5},
                   n: 10, last: 1'b1, idx_tl: 4'd4, idx_tf: 4'd3, value: 32'd9, err: 1'b0};
        tbl[1] = '{vals: '{default: 32'd5},
                   n: 10, last: 1'b1, idx_tl: 4'd9, idx_tf: 4'd0, value: 32'd5, err: 1'b0};
        tbl[2] = '{vals: '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'hFFFF_FFFF},
                   n: 10, last: 1'b1, idx_tl: 4'd9, idx_tf: 4'd9, value: 32'hFFFF_FFFF, err: 1'b0};
        tbl[3] = '{vals: '{32'd100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9},
                   n: 10, last: 1'b1, idx_tl: 4'd0, idx_tf: 4'd0, value: 32'd100, err: 1'b0};
        tbl[4] = '{vals: '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd9, 32'd7, 32'd5, 32'd3, 32'd1},
                   n: 10, last: 1'b0, idx_tl: 4'd4, idx_tf: 4'd4, value: 32'd10, err: 1'b1};
        tbl[5] = '{vals: '{0: 32'd1, 1: 32'd6, 2: 32'd2, 3: 32'd3, default: 32'd0},
                   n: 4, last: 1'b1, idx_tl: 4'd1, idx_tf: 4'd1, value: 32'd6, err: 1'b1};
        tbl[6] = '{vals: '{0: 32'd42, default: 32'd0},
                   n: 1, last: 1'b1, idx_tl: 4'd0, idx_tf: 4'd0, value: 32'd42, err: 1'b1};
        tbl[7] = '{vals: '{0: 32'd7, default: 32'd0},
                   n: 1, last: 1'b1, idx_tl: 4'd0, idx_tf: 4'd0, value: 32'd7, err: 1'b1};
        tbl[8] = '{vals: '{0: 32'd9, 1: 32'd3, 2: 32'd9, default: 32'd0},
                   n: 3, last: 1'b1, idx_tl: 4'd2, idx_tf: 4'd0, value: 32'd9, err: 1'b1};

        sneg  = '{-32'sd5, -32'sd2, -32'sd9, -32'sd3, -32'sd4, -32'sd7, -32'sd8, -32'sd6, -32'sd10, -32'sd3};
        clean = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50, 32'd60, 32'd70, 32'd80, 32'd90, 32'd15};
        stall_vec = '{32'd77, 32'd3, 32'd80, 32'd80, 32'd1, 32'd2, 32'd0, 32'd4, 32'd79, 32'd5};

        #12;
        check("reset_out_valid", 32'(ov_u), 32'd0);
        check("reset_out_index", 32'(oi_u), 32'd0);
        check("reset_out_value", ovl_u, 32'd0);
        check("reset_out_error", 32'(oe_u), 32'd0);
        check("reset_in_ready", 32'(rdy_u), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back vectors with in_valid held high and out_ready=1.
        for (int t = 0; t < 9; t++) begin
            for (int unsigned e = 0; e < tbl[t].n; e++) begin
                push(tbl[t].vals[e], (e == tbl[t].n - 1) ? tbl[t].last : 1'b0);
            end
            check($sformatf("v%0d_out_valid", t), 32'(ov_u), 32'd1);
            check($sformatf("v%0d_index", t), 32'(oi_u), 32'(tbl[t].idx_tl));
            check($sformatf("v%0d_value", t), ovl_u, tbl[t].value);
            check($sformatf("v%0d_error", t), 32'(oe_u), 32'(tbl[t].err));
            check($sformatf("v%0d_index_keep_first", t), 32'(oi_f), 32'(tbl[t].idx_tf));
        end
        check("b2b_stall_cycles", stalls, 32'd0);
        idle();
        check("b2b_consumed", 32'(ov_u), 32'd0);

        // Signed compare.
        for (int e = 0; e < 10; e++) push(sneg[e], (e == 9) ? 1'b1 : 1'b0);
        check("signed_index", 32'(oi_s), 32'd1);
        check("signed_value", ovl_s, 32'hFFFF_FFFE);
        check("signed_error", 32'(oe_s), 32'd0);
        push(32'd5, 1'b0);
        push(32'hFFFF_FFFF, 1'b1);
        check("mixed_signed_index", 32'(oi_s), 32'd0);
        check("mixed_signed_value", ovl_s, 32'd5);
        check("mixed_signed_error", 32'(oe_s), 32'd1);
        check("mixed_unsigned_index", 32'(oi_u), 32'd1);
        check("mixed_unsigned_value", ovl_u, 32'hFFFF_FFFF);
        idle();

        // Pending result with out_ready=0 stalls the next vector.
        out_ready = 1'b0;
        push(32'd1, 1'b0); push(32'd6, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b1);
        check("stall_first_valid", 32'(ov_u), 32'd1);
        check("stall_first_index", 32'(oi_u), 32'd1);
        in_valid = 1'b1; in_value = stall_vec[0]; in_last = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_in_ready_%0d", c), 32'(rdy_u), 32'd0);
            check($sformatf("stall_hold_value_%0d", c), ovl_u, 32'd6);
            check($sformatf("stall_hold_index_%0d", c), 32'(oi_u), 32'd1);
            check($sformatf("stall_hold_error_%0d", c), 32'(oe_u), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_released_consumed", 32'(ov_u), 32'd0);
        for (int e = 1; e < 10; e++) push(stall_vec[e], (e == 9) ? 1'b1 : 1'b0);
        check("stall_second_index", 32'(oi_u), 32'd3);
        check("stall_second_value", ovl_u, 32'd80);
        check("stall_second_error", 32'(oe_u), 32'd0);
        check("stall_second_index_keep_first", 32'(oi_f), 32'd2);
        idle();

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        push(32'd1, 1'b0); push(32'd6, 1'b0); push(32'd2, 1'b0); push(32'd3, 1'b1);
        idle();
        check("pending_before_reset", 32'(ov_u), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 32'(ov_u), 32'd0);
        check("async_reset_out_index", 32'(oi_u), 32'd0);
        check("async_reset_out_value", ovl_u, 32'd0);
        check("async_reset_out_error", 32'(oe_u), 32'd0);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-vector, then a clean vector.
        for (int e = 0; e < 5; e++) push(32'd200 + 32'(e), 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midvec_reset_out_valid", 32'(ov_u), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int e = 0; e < 10; e++) push(clean[e], (e == 9) ? 1'b1 : 1'b0);
        check("post_reset_valid", 32'(ov_u), 32'd1);
        check("post_reset_index", 32'(oi_u), 32'd8);
        check("post_reset_value", ovl_u, 32'd90);
        check("post_reset_error", 32'(oe_u), 32'd0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
